ltl_monitor_cluster_agg: RTL and testbench

Parametrised result aggregator for a cluster of LTL runtime monitors. It sits between the automata stage and the system's reporting path. It takes the raw report-state vector of every property automaton and OR-reduces it per property, qualified by run and a per-property enable. It then keeps a registered hit flag, a sticky violation flag and a saturating hit counter for each property, and serialises hits into a timestamped event stream with a valid/ready handshake.

---
 rtl/ltl_mon_pkg.sv | 34 +++
 rtl/ltl_monitor_cluster_agg_fifo.sv | 49 ++++
 rtl/ltl_monitor_cluster_agg.sv | 167 ++++++++++++++++
 tb/tb_ltl_monitor_cluster_agg.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ltl_mon_pkg.sv
// Shared types, constants and helpers for the LTL monitor cluster aggregator.
package ltl_mon_pkg;

    // Width of the lost-event counter.
    localparam int DROP_W = 16;

    // Widest supported event fields: up to 32 properties, up to 64-bit timestamps.
    localparam int EVT_ID_MAX_W = 5;
    localparam int EVT_TS_MAX_W = 64;

    // Canonical event record at the widest supported field sizes. The aggregator
    // stores a width-exact copy in its FIFO; consumers widen into this form.
    typedef struct packed {
        logic [EVT_ID_MAX_W-1:0] id;
        logic [EVT_TS_MAX_W-1:0] ts;
    } ltl_evt_t;

    // Property index width, never less than one bit.
    function automatic int id_width(input int num_props);
        return (num_props > 1) ? $clog2(num_props) : 1;
    endfunction

    // Saturating add for counters of width w (w <= 32).
    function automatic logic [31:0] sat_add(input logic [31:0] v,
                                            input logic [31:0] inc,
                                            input int          w);
        logic [32:0] sum;
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        sum   = {1'b0, v} + {1'b0, inc};
        return (sum > {1'b0, max_v}) ? max_v : sum[31:0];
    endfunction

endpackage

// File: rtl/ltl_monitor_cluster_agg_fifo.sv
// Synchronous event FIFO with simultaneous push/pop; a push while full is
// accepted only when a pop frees a slot in the same cycle.
module ltl_event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Payload storage; not reset, stale entries are masked by the empty flag.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    // Head is forced to zero when empty so the outputs read 0 straight after reset.
    assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ltl_monitor_cluster_agg.sv
// Result aggregator for a cluster of LTL runtime monitors: per-property hit,
// sticky violation and saturating hit counter, plus a timestamped event stream.
module ltl_monitor_cluster_agg
    import ltl_mon_pkg::*;
#(
    parameter int NUM_PROPS     = 10,
    parameter int REPORT_STATES = 4,
    parameter int CNT_W         = 16,
    parameter int TS_W          = 32,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               run,
    input  logic [NUM_PROPS-1:0]               enable,
    input  logic [NUM_PROPS*REPORT_STATES-1:0] report,
    input  logic [NUM_PROPS-1:0]               clr,
    output logic [NUM_PROPS-1:0]               ltl_hit,
    output logic [NUM_PROPS-1:0]               ltl_sticky,
    output logic                               any_violation,
    output logic [NUM_PROPS*CNT_W-1:0]         hit_count,
    output logic                               evt_valid,
    input  logic                               evt_ready,
    output logic [id_width(NUM_PROPS)-1:0]     evt_id,
    output logic [TS_W-1:0]                    evt_ts,
    output logic [DROP_W-1:0]                  drop_count
);
    localparam int ID_W = id_width(NUM_PROPS);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [TS_W-1:0] ts;
    } evt_t;

    logic [NUM_PROPS-1:0] hit_raw;
    logic [NUM_PROPS-1:0] hit_q;
    logic [NUM_PROPS-1:0] sticky_q, sticky_d;
    logic [NUM_PROPS-1:0] pend_q, pend_d;
    logic [CNT_W-1:0]     cnt_q [NUM_PROPS];
    logic [CNT_W-1:0]     cnt_d [NUM_PROPS];
    logic [TS_W-1:0]      pts_q [NUM_PROPS];
    logic [TS_W-1:0]      pts_d [NUM_PROPS];
    logic [TS_W-1:0]      ts_q, ts_d;
    logic [DROP_W-1:0]    drop_q, drop_d;
    logic [31:0]          lost_cnt;

    logic                 enq_found;
    logic [ID_W-1:0]      enq_idx;
    logic [TS_W-1:0]      enq_ts;
    logic                 push, pop, fifo_full, fifo_empty;
    evt_t                 push_evt, head_evt;

    // Raw hit: symbol valid, property enabled and any report state active.
    always_comb begin
        hit_raw = '0;
        for (int i = 0; i < NUM_PROPS; i++) begin
            hit_raw[i] = run & enable[i] & (|report[i*REPORT_STATES +: REPORT_STATES]);
        end
    end

    // Priority encoder: the lowest-index pending property takes the single enqueue slot.
    always_comb begin
        enq_found = 1'b0;
        enq_idx   = '0;
        enq_ts    = '0;
        for (int i = NUM_PROPS - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                enq_found = 1'b1;
                enq_idx   = ID_W'(i);
                enq_ts    = pts_q[i];
            end
        end
    end

    assign pop      = ~fifo_empty & evt_ready;
    assign push     = enq_found & (~fifo_full | pop);
    assign push_evt = '{id: enq_idx, ts: enq_ts};

    // Next state for timestamp, sticky flags, counters, pending mask and drop count.
    always_comb begin
        ts_d     = run ? ts_q + TS_W'(1) : ts_q;
        lost_cnt = '0;
        sticky_d = sticky_q;
        pend_d   = pend_q;
        for (int i = 0; i < NUM_PROPS; i++) begin
            // A hit in the same cycle as clr keeps the flag set.
            sticky_d[i] = hit_raw[i] | (sticky_q[i] & ~clr[i]);

            if (clr[i]) begin
                cnt_d[i] = hit_raw[i] ? CNT_W'(1) : '0;
            end else if (hit_raw[i]) begin
                cnt_d[i] = CNT_W'(sat_add(32'(cnt_q[i]), 32'd1, CNT_W));
            end else begin
                cnt_d[i] = cnt_q[i];
            end

            pts_d[i] = pts_q[i];
            if (push && (enq_idx == ID_W'(i))) pend_d[i] = 1'b0;
            // A slot freed by this cycle's enqueue can take the new hit; otherwise it is lost.
            if (hit_raw[i]) begin
                if (pend_d[i]) begin
                    lost_cnt = lost_cnt + 32'd1;
                end else begin
                    pend_d[i] = 1'b1;
                    pts_d[i]  = ts_q;
                end
            end
        end
        drop_d = DROP_W'(sat_add(32'(drop_q), lost_cnt, DROP_W));
    end

    // State registers; reset clears everything, including in-flight pending bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q     <= '0;
            hit_q    <= '0;
            sticky_q <= '0;
            pend_q   <= '0;
            drop_q   <= '0;
            for (int i = 0; i < NUM_PROPS; i++) begin
                cnt_q[i] <= '0;
                pts_q[i] <= '0;
            end
        end else begin
            ts_q     <= ts_d;
            hit_q    <= hit_raw;
            sticky_q <= sticky_d;
            pend_q   <= pend_d;
            drop_q   <= drop_d;
            for (int i = 0; i < NUM_PROPS; i++) begin
                cnt_q[i] <= cnt_d[i];
                pts_q[i] <= pts_d[i];
            end
        end
    end

    ltl_event_fifo #(
        .WIDTH (ID_W + TS_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (push),
        .din_i   (push_evt),
        .pop_i   (pop),
        .dout_o  (head_evt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Flatten per-property counters onto the output bus.
    always_comb begin
        hit_count = '0;
        for (int i = 0; i < NUM_PROPS; i++) begin
            hit_count[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    assign ltl_hit       = hit_q;
    assign ltl_sticky    = sticky_q;
    assign any_violation = |sticky_q;
    assign drop_count    = drop_q;
    assign evt_valid     = ~fifo_empty;
    assign evt_id        = head_evt.id;
    assign evt_ts        = head_evt.ts;

endmodule

// File: tb/tb_ltl_monitor_cluster_agg.sv
// Scoreboard bench for ltl_monitor_cluster_agg with a behavioural reference model.
module tb_ltl_monitor_cluster_agg;
    import ltl_mon_pkg::*;

    localparam int NP      = 10;
    localparam int RS      = 4;
    localparam int CW      = 4;
    localparam int TW      = 32;
    localparam int FD      = 8;
    localparam int IW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            reset, run, evt_ready;
    logic [NP-1:0]   enable, clr, ltl_hit, ltl_sticky;
    logic [NP*RS-1:0] report;
    logic            any_violation, evt_valid;
    logic [NP*CW-1:0] hit_count;
    logic [IW-1:0]   evt_id;
    logic [TW-1:0]   evt_ts;
    logic [DROP_W-1:0] drop_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit       m_hit [NP];
    bit       m_sticky [NP];
    bit       m_pend [NP];
    int       m_cnt [NP];
    longint   m_pts [NP];
    longint   m_ts;
    int       m_drop;
    int       m_occ;
    ltl_evt_t exp_q [$];

    always #5 clk = ~clk;

    ltl_monitor_cluster_agg #(
        .NUM_PROPS(NP), .REPORT_STATES(RS), .CNT_W(CW), .TS_W(TW), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .enable(enable), .report(report),
        .clr(clr), .ltl_hit(ltl_hit), .ltl_sticky(ltl_sticky),
        .any_violation(any_violation), .hit_count(hit_count),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
        .evt_ts(evt_ts), .drop_count(drop_count)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            m_hit[i] = 0; m_sticky[i] = 0; m_pend[i] = 0; m_cnt[i] = 0; m_pts[i] = 0;
        end
        m_ts = 0; m_drop = 0; m_occ = 0;
        exp_q.delete();
    endtask

    // One clock edge of the reference behaviour, using the inputs held before the edge.
    task automatic model_step();
        bit h [NP];
        bit pop, enq;
        int sel;
        if (reset) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NP; i++) h[i] = run && enable[i] && (report[i*RS +: RS] != 0);
        pop = (m_occ > 0) && evt_ready;
        sel = -1;
        for (int i = NP - 1; i >= 0; i--) if (m_pend[i]) sel = i;
        enq = (sel >= 0) && ((m_occ < FD) || pop);
        if (enq) begin
            exp_q.push_back('{id: 5'(sel), ts: 64'(m_pts[sel])});
            m_pend[sel] = 0;
        end
        m_occ = m_occ + int'(enq) - int'(pop);
        for (int i = 0; i < NP; i++) begin
            m_hit[i] = h[i];
            if (h[i]) m_sticky[i] = 1;
            else if (clr[i]) m_sticky[i] = 0;
            if (clr[i]) m_cnt[i] = h[i] ? 1 : 0;
            else if (h[i] && m_cnt[i] < CNT_MAX) m_cnt[i]++;
            if (h[i]) begin
                if (m_pend[i]) begin
                    if (m_drop < 65535) m_drop++;
                end else begin
                    m_pend[i] = 1;
                    m_pts[i]  = m_ts;
                end
            end
        end
        if (run) m_ts = (m_ts + 1) % (longint'(1) << TW);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            model_step();
            #1;
        end
    endtask

    // Monitor: compare registered outputs and the event stream against the model.
    always @(negedge clk) begin : monitor
        logic [NP-1:0]    eh, es;
        logic [NP*CW-1:0] ec;
        if (!reset) begin
            for (int i = 0; i < NP; i++) begin
                eh[i] = m_hit[i];
                es[i] = m_sticky[i];
                ec[i*CW +: CW] = CW'(m_cnt[i]);
            end
            chk("ltl_hit", ltl_hit, eh);
            chk("ltl_sticky", ltl_sticky, es);
            chk("any_violation", any_violation, |es);
            chk("hit_count", hit_count, ec);
            chk("drop_count", drop_count, m_drop);
            chk("evt_valid", evt_valid, m_occ > 0);
            if (evt_valid) begin
                chk("scoreboard_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    chk("evt_id", evt_id, exp_q[0].id);
                    chk("evt_ts", evt_ts, exp_q[0].ts);
                    if (evt_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        reset = 1'b1; run = 1'b0; enable = '0; report = '0; clr = '0; evt_ready = 1'b0;
        tick(3);
        reset = 1'b0;

        // Single hit on property 3 at ts=5
        run = 1'b1; enable = '1;
        tick(5);
        report[13] = 1'b1;
        tick(1);
        report = '0;
        chk("single_hit_flag", ltl_hit, 10'h008);
        tick(1);
        chk("single_hit_pulse", ltl_hit, 0);
        chk("single_evt_valid", evt_valid, 1);
        chk("single_evt_id", evt_id, 3);
        chk("single_evt_ts", evt_ts, 5);
        tick(2);
        evt_ready = 1'b1;
        tick(3);

        // Simultaneous hits on properties 7, 2 and 0
        report[0*RS + 0] = 1'b1; report[2*RS + 1] = 1'b1; report[7*RS + 3] = 1'b1;
        tick(1);
        report = '0;
        tick(6);
        chk("simul_no_drop", drop_count, 0);

        // Backpressure with property 1 hitting continuously
        evt_ready = 1'b0;
        report[1*RS + 2] = 1'b1;
        tick(12);
        report = '0;
        tick(3);
        evt_ready = 1'b1;
        tick(14);

        // Clear every property
        clr = '1;
        tick(1);
        clr = '0;
        chk("clear_all_violation", any_violation, 0);

        // Counter saturation and clr corners on property 5
        report[5*RS] = 1'b1;
        tick(20);
        chk("cnt5_saturated", hit_count[5*CW +: CW], 15);
        clr[5] = 1'b1;
        tick(1);
        clr = '0; report = '0;
        chk("cnt5_clr_with_hit", hit_count[5*CW +: CW], 1);
        chk("sticky5_clr_with_hit", ltl_sticky[5], 1);
        clr[5] = 1'b1;
        tick(1);
        clr = '0;
        chk("cnt5_clr_alone", hit_count[5*CW +: CW], 0);
        chk("sticky5_clr_alone", ltl_sticky[5], 0);
        chk("violation_dropped", any_violation, 0);
        tick(4);

        // Masked property and run gating
        enable[4] = 1'b0;
        report[4*RS + 1] = 1'b1;
        tick(3);
        chk("masked_hit", ltl_hit[4], 0);
        chk("masked_count", hit_count[4*CW +: CW], 0);
        report = '0; enable = '1;
        run = 1'b0; report = '1;
        tick(3);
        chk("run0_hits", ltl_hit, 0);
        report = '0; run = 1'b1;
        tick(2);

        // Fill the FIFO, then assert reset asynchronously mid-cycle
        evt_ready = 1'b0;
        repeat (30) begin
            for (int i = 0; i < NP; i++) report[i*RS +: RS] = ($urandom_range(0, 1) == 0) ? RS'($urandom_range(1, 15)) : '0;
            tick(1);
        end
        report = '0;
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_ltl_hit", ltl_hit, 0);
        chk("rst_sticky", ltl_sticky, 0);
        chk("rst_any_violation", any_violation, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_evt_valid", evt_valid, 0);
        chk("rst_evt_id", evt_id, 0);
        chk("rst_evt_ts", evt_ts, 0);
        chk("rst_drop_count", drop_count, 0);
        tick(2);
        reset = 1'b0;
        report[6*RS] = 1'b1;
        tick(1);
        report = '0;
        tick(1);
        chk("post_rst_evt_valid", evt_valid, 1);
        chk("post_rst_evt_id", evt_id, 6);
        chk("post_rst_evt_ts", evt_ts, 0);
        evt_ready = 1'b1;
        tick(2);

        // Randomised traffic
        repeat (3000) begin
            run = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < NP; i++) begin
                report[i*RS +: RS] = ($urandom_range(0, 9) == 0) ? RS'($urandom_range(1, 15)) : '0;
                enable[i] = ($urandom_range(0, 9) != 0);
                clr[i]    = ($urandom_range(0, 29) == 0);
            end
            evt_ready = ($urandom_range(0, 9) < 6);
            tick(1);
        end

        // Drain
        run = 1'b1; report = '0; clr = '0; enable = '1; evt_ready = 1'b1;
        tick(40);
        chk("drain_scoreboard_left", exp_q.size(), 0);
        chk("drain_evt_valid", evt_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
